// File: rtl/scfifo_pkg.sv
// Shared constants and helpers for the scfifo stream reader.
package scfifo_pkg;

  // Legal scfifo read latencies: without / with the RAM output register
  localparam int unsigned RL_NO_OUTREG = 1;
  localparam int unsigned RL_OUTREG    = 2;

  // True when the latency matches one of the scfifo output modes
  function automatic bit rl_is_legal(input int unsigned rl);
    return (rl == RL_NO_OUTREG) || (rl == RL_OUTREG);
  endfunction

  // Bits needed to hold a count from 0 up to depth inclusive
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/scfifo_reader_skid.sv
// Circular skid buffer: push at the tail, pop from the head, registered count.
module scfifo_reader_skid
  import scfifo_pkg::*;
#(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 2
) (
  input  logic                            clock,
  input  logic                            sclr,
  input  logic                            push,
  input  logic [WIDTH-1:0]                push_data,
  input  logic                            pop,
  output logic                            valid,
  output logic [WIDTH-1:0]                head,
  output logic [count_width(DEPTH)-1:0]   count
);

  localparam int unsigned CW = count_width(DEPTH);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  // Pointers wrap by explicit compare so any depth works
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop & valid;
  assign head   = mem[rd_ptr];

  // Storage write at the tail; contents need no reset
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer, count and valid bookkeeping
  always_ff @(posedge clock) begin
    if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, do_pop})
        2'b10: begin
          count <= count + CW'(1);
          valid <= 1'b1;
        end
        2'b01: begin
          count <= count - CW'(1);
          valid <= (count != CW'(1));
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/scfifo_stream_reader.sv
// Turns a non-showahead scfifo into a valid/ready stream via a skid buffer.
module scfifo_stream_reader
  import scfifo_pkg::*;
#(
  parameter int unsigned WIDTH        = 20,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned BUF_DEPTH    = READ_LATENCY + 1
) (
  input  logic                              clock,
  input  logic                              sclr,
  input  logic                              fifo_empty,
  input  logic [WIDTH-1:0]                  fifo_q,
  output logic                              fifo_rdreq,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_data,
  output logic [count_width(BUF_DEPTH)-1:0] out_count
);

  localparam int unsigned CW = count_width(BUF_DEPTH);
  localparam int unsigned OW = CW + 1;

  // Reject latencies the scfifo cannot produce and buffers too small to stream
  if (!rl_is_legal(READ_LATENCY)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (BUF_DEPTH < READ_LATENCY + 1) begin : g_bad_depth
    $error("BUF_DEPTH must be at least READ_LATENCY+1");
  end

  logic [READ_LATENCY-1:0] rd_pipe;
  logic                    capture;
  logic                    pop;
  logic [OW-1:0]           inflight;
  logic [OW-1:0]           occupancy;

  assign capture = rd_pipe[READ_LATENCY-1];
  assign pop     = out_valid & out_ready;

  // Track issued reads until their data returns; sclr drops pending returns
  always_ff @(posedge clock) begin
    if (sclr) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= READ_LATENCY'({rd_pipe, fifo_rdreq});
    end
  end

  // Reserve buffer space for reads in flight before issuing another
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + OW'(rd_pipe[i]);
    end
    occupancy  = OW'(out_count) + inflight - OW'(pop);
    fifo_rdreq = !fifo_empty && !sclr && (occupancy < OW'(BUF_DEPTH));
  end

  scfifo_reader_skid #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_skid (
    .clock     (clock),
    .sclr      (sclr),
    .push      (capture),
    .push_data (fifo_q),
    .pop       (out_ready),
    .valid     (out_valid),
    .head      (out_data),
    .count     (out_count)
  );

endmodule

// File: tb/tb_scfifo_stream_reader.sv
// Bench: two readers (latency 1 and 2), each fed by a behavioural scfifo model.
module tb_scfifo_stream_reader;

  localparam int unsigned W   = 20;
  localparam int unsigned N   = 2;
  localparam int unsigned FD  = 64;
  localparam int unsigned EXD = 1024;

  logic                clk;
  logic                sclr;
  logic [N-1:0]        wr;
  logic [N-1:0]        rdy;
  logic [N-1:0]        fifo_empty;
  logic [N-1:0]        rdreq;
  logic [N-1:0]        out_valid;
  logic [N-1:0][W-1:0] wdata;
  logic [N-1:0][W-1:0] fifo_q;
  logic [N-1:0][W-1:0] out_data;
  logic [N-1:0][1:0]   out_count;

  // scfifo model state
  logic [W-1:0]        f_mem [N][FD];
  logic [5:0]          f_wp  [N];
  logic [5:0]          f_rp  [N];
  logic [6:0]          f_cnt [N];
  logic [N-1:0][W-1:0] q_s1;
  logic [N-1:0][W-1:0] q_s2;

  // scoreboard: written words in order, consumed by the monitor
  logic [W-1:0] exp_mem [N][EXD];
  int unsigned  exp_wr [N];
  int unsigned  exp_rd [N];

  int   tests;
  int   fails;
  logic done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  scfifo_stream_reader #(.WIDTH(W), .READ_LATENCY(1)) u_rl1 (
    .clock(clk), .sclr(sclr), .fifo_empty(fifo_empty[0]), .fifo_q(fifo_q[0]),
    .fifo_rdreq(rdreq[0]), .out_valid(out_valid[0]), .out_ready(rdy[0]),
    .out_data(out_data[0]), .out_count(out_count[0]));

  scfifo_stream_reader #(.WIDTH(W), .READ_LATENCY(2)) u_rl2 (
    .clock(clk), .sclr(sclr), .fifo_empty(fifo_empty[1]), .fifo_q(fifo_q[1]),
    .fifo_rdreq(rdreq[1]), .out_valid(out_valid[1]), .out_ready(rdy[1]),
    .out_data(out_data[1]), .out_count(out_count[1]));

  assign fifo_empty[0] = (f_cnt[0] == 7'd0);
  assign fifo_empty[1] = (f_cnt[1] == 7'd0);
  assign fifo_q[0]     = q_s1[0];
  assign fifo_q[1]     = q_s2[1];

  // Non-showahead scfifo; instance 1 adds the RAM output register
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (sclr) begin
        f_wp[k]  <= '0;
        f_rp[k]  <= '0;
        f_cnt[k] <= '0;
      end else begin
        if (wr[k]) begin
          f_mem[k][f_wp[k]] <= wdata[k];
          f_wp[k] <= f_wp[k] + 6'd1;
          exp_mem[k][10'(exp_wr[k])] <= wdata[k];
          exp_wr[k] <= exp_wr[k] + 1;
        end
        if (rdreq[k]) begin
          q_s1[k] <= f_mem[k][f_rp[k]];
          f_rp[k] <= f_rp[k] + 6'd1;
        end
        f_cnt[k] <= f_cnt[k] + 7'(wr[k]) - 7'(rdreq[k]);
      end
      q_s2[k] <= q_s1[k];
    end
  end

  task automatic check(input string name, input int k, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", name, k, act, want);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, settle, return
  task automatic cyc(input logic [N-1:0] w, input logic [N-1:0][W-1:0] d,
                     input logic [N-1:0] r, input logic s);
    @(negedge clk);
    wr    = w;
    wdata = d;
    rdy   = r;
    sclr  = s;
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) cyc('0, '0, '1, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks protocol rules
  task automatic monitor();
    logic [N-1:0]        stall;
    logic [N-1:0][W-1:0] held;
    logic                sclr_q;
    stall  = '0;
    held   = '0;
    sclr_q = 1'b1;
    while (!done) begin
      @(negedge clk);
      #2;
      for (int k = 0; k < N; k++) begin
        if (sclr_q) begin
          check("rst_valid", k, int'(out_valid[k]), 0);
          check("rst_count", k, int'(out_count[k]), 0);
        end
        if (sclr) begin
          check("rdreq_in_sclr", k, int'(rdreq[k]), 0);
          exp_rd[k] = exp_wr[k];
          stall[k]  = 1'b0;
        end else begin
          if (rdreq[k]) check("rdreq_on_empty", k, int'(fifo_empty[k]), 0);
          if (stall[k]) begin
            check("hold_valid", k, int'(out_valid[k]), 1);
            check("hold_data", k, int'(out_data[k]), int'(held[k]));
          end
          if (out_valid[k] && rdy[k]) begin
            if (exp_rd[k] == exp_wr[k]) begin
              tests++;
              fails++;
              $display("FAIL sb_extra inst%0d: got 0x%0h, expected no word", k, out_data[k]);
            end else begin
              check("sb_data", k, int'(out_data[k]), int'(exp_mem[k][10'(exp_rd[k])]));
              exp_rd[k] = exp_rd[k] + 1;
            end
          end
          stall[k] = out_valid[k] & ~rdy[k];
          held[k]  = out_data[k];
        end
      end
      sclr_q = sclr;
    end
  endtask

  task automatic stimulus();
    logic [N-1:0][W-1:0] d;
    logic [N-1:0]        w;
    logic [N-1:0]        r;
    int first_rd [N];
    int first_v  [N];
    int last_v   [N];
    int nx       [N];
    int nrd      [N];
    int exp_cnt  [N][4];
    bit seen;
    int got;
    exp_cnt = '{'{2, 1, 1, 1}, '{3, 2, 1, 1}};

    // reset
    repeat (3) cyc('0, '0, '0, 1'b1);
    for (int k = 0; k < N; k++) begin
      check("reset_valid", k, int'(out_valid[k]), 0);
      check("reset_count", k, int'(out_count[k]), 0);
      check("reset_rdreq", k, int'(rdreq[k]), 0);
    end

    // streaming 10..41 with the consumer always ready
    for (int k = 0; k < N; k++) begin
      first_rd[k] = -1; first_v[k] = -1; last_v[k] = -1; nx[k] = 0;
    end
    for (int i = 0; i < 46; i++) begin
      for (int k = 0; k < N; k++) d[k] = W'(10 + i);
      cyc((i < 32) ? 2'b11 : 2'b00, d, 2'b11, 1'b0);
      for (int k = 0; k < N; k++) begin
        if (rdreq[k] && first_rd[k] < 0) first_rd[k] = i;
        if (out_valid[k] && rdy[k]) begin
          if (first_v[k] < 0) first_v[k] = i;
          last_v[k] = i;
          nx[k]++;
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      check("stream_latency", k, first_v[k] - first_rd[k], k + 2);
      check("stream_words", k, nx[k], 32);
      check("stream_span", k, last_v[k] - first_v[k], 31);
    end

    // backpressure: consumer stalled while the FIFO stays non-empty
    for (int k = 0; k < N; k++) nrd[k] = 0;
    for (int i = 0; i < 28; i++) begin
      for (int k = 0; k < N; k++) d[k] = W'(100 + i);
      cyc((i < 8) ? 2'b11 : 2'b00, d, 2'b00, 1'b0);
      for (int k = 0; k < N; k++) if (rdreq[k]) nrd[k]++;
    end
    for (int k = 0; k < N; k++) begin
      check("bp_rdreqs", k, nrd[k], k + 2);
      check("bp_count", k, int'(out_count[k]), k + 2);
      check("bp_head", k, int'(out_data[k]), 100);
    end
    drain(25);
    for (int k = 0; k < N; k++) check("bp_drained", k, int'(out_valid[k]), 0);

    // single word into an empty FIFO
    for (int k = 0; k < N; k++) begin
      nrd[k] = 0; nx[k] = 0; d[k] = W'(200);
    end
    for (int i = 0; i < 10; i++) begin
      cyc((i == 0) ? 2'b11 : 2'b00, d, 2'b11, 1'b0);
      for (int k = 0; k < N; k++) begin
        if (rdreq[k]) nrd[k]++;
        if (out_valid[k] && rdy[k]) nx[k]++;
      end
    end
    for (int k = 0; k < N; k++) begin
      check("empty_rdreqs", k, nrd[k], 1);
      check("empty_xfers", k, nx[k], 1);
      check("empty_rdreq_idle", k, int'(rdreq[k]), 0);
      check("empty_valid_idle", k, int'(out_valid[k]), 0);
    end

    // full buffer, then pop and capture in the same cycle
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < N; k++) d[k] = W'(400 + i);
      cyc((i < 6) ? 2'b11 : 2'b00, d, 2'b00, 1'b0);
    end
    for (int k = 0; k < N; k++) check("full_count", k, int'(out_count[k]), k + 2);
    for (int i = 0; i < 4; i++) begin
      cyc('0, '0, '1, 1'b0);
      for (int k = 0; k < N; k++) begin
        check("simul_count", k, int'(out_count[k]), exp_cnt[k][i]);
        check("simul_head", k, int'(out_data[k]), 400 + i);
      end
    end
    drain(15);

    // sclr one cycle after a read on the latency-2 reader
    d = '0;
    d[1] = W'(300);
    cyc(2'b10, d, '1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc('0, '0, '1, 1'b0);
      if (rdreq[1]) seen = 1'b1;
    end
    check("mid_rdreq_seen", 1, int'(seen), 1);
    cyc('0, '0, '1, 1'b1);
    nx[1] = 0;
    for (int i = 0; i < 8; i++) begin
      cyc('0, '0, '1, 1'b0);
      if (out_valid[1]) nx[1]++;
    end
    check("mid_no_capture", 1, nx[1], 0);
    d[1] = W'(301);
    cyc(2'b10, d, '1, 1'b0);
    seen = 1'b0;
    got  = -1;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc('0, '0, '1, 1'b0);
      if (out_valid[1]) begin
        seen = 1'b1;
        got  = int'(out_data[1]);
      end
    end
    check("mid_next_word", 1, got, 301);
    drain(10);

    // random writes and random consumer readiness
    for (int i = 0; i < 10000; i++) begin
      for (int k = 0; k < N; k++) begin
        w[k] = ($urandom_range(0, 2) != 0) && (f_cnt[k] < 7'd48);
        r[k] = ($urandom_range(0, 3) < ((((i / 500) % 2) == 1) ? 3 : 1));
        d[k] = W'($urandom);
      end
      cyc(w, d, r, 1'b0);
    end
    drain(80);
    for (int k = 0; k < N; k++) begin
      check("rand_all_consumed", k, int'(exp_rd[k]), int'(exp_wr[k]));
      check("rand_idle_valid", k, int'(out_valid[k]), 0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    done  = 1'b0;
    wr    = '0;
    wdata = '0;
    rdy   = '0;
    sclr  = 1'b1;
    fork
      monitor();
      begin
        stimulus();
        done = 1'b1;
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scfifo_stream_reader.md
SCFIFO_STREAM_READER -- requirements
Module: scfifo_stream_reader

Interface
REQ-001 Parameter WIDTH, default 20, data width; SHALL match lpm_width of the attached scfifo.
REQ-002 Parameter READ_LATENCY, default 1, cycles from rdreq to valid q; legal values 1 (add_ram_output_register OFF) and 2 (ON); any other value SHALL fail elaboration.
REQ-003 Parameter BUF_DEPTH, default READ_LATENCY+1, skid-buffer entries; values below READ_LATENCY+1 SHALL fail elaboration.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 sclr  input  1  reset, synchronous, active-high; the attached scfifo SHALL share this sclr.
REQ-006 fifo_empty  input  1  empty flag from the non-showahead scfifo.
REQ-007 fifo_q  input  WIDTH  q from the scfifo.
REQ-008 fifo_rdreq  output  1  read request to the scfifo.
REQ-009 out_valid  output  1  out_data holds a word.
REQ-010 out_ready  input  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-011 out_data  output  WIDTH  head word of the skid buffer.
REQ-012 out_count  output  $clog2(BUF_DEPTH+1)  words currently held in the skid buffer.

Function
REQ-013 Word order SHALL be preserved exactly: words SHALL appear on out_data in scfifo read order, with no loss and no duplication.
REQ-014 fifo_rdreq SHALL be high only when fifo_empty=0 and sclr=0 and (out_count + inflight - pop) < BUF_DEPTH, where pop = out_valid & out_ready in the same cycle.
REQ-015 inflight SHALL count rdreqs issued within the last READ_LATENCY cycles, tracked by a READ_LATENCY-bit shift register of issued rdreq flags.
REQ-016 A rdreq in cycle t SHALL cause fifo_q to be captured into the buffer at the end of cycle t+READ_LATENCY; out_valid SHALL be high no earlier than cycle t+READ_LATENCY+1.
REQ-017 Fall-through is forbidden: out_data and out_valid SHALL come from registers only, with no combinational path from fifo_q, fifo_empty or out_ready.
REQ-018 fifo_rdreq SHALL be combinational from registered state, fifo_empty and out_ready.
REQ-019 When pop and capture occur in the same cycle, out_count SHALL remain unchanged and head and tail SHALL both advance.
REQ-020 Buffer pointers SHALL wrap modulo BUF_DEPTH; for non-power-of-2 depths they SHALL use an explicit compare-and-reset.
REQ-021 out_count SHALL never exceed BUF_DEPTH, and a capture SHALL never occur into a full buffer; this is guaranteed by REQ-014.
REQ-022 With out_ready held at 1 and the scfifo never empty, sustained throughput SHALL be 1 word per cycle after the initial latency.
REQ-023 When out_valid=1 and out_ready=0, out_data SHALL hold stable.

Reset
REQ-024 While sclr=1: out_valid=0, out_count=0, fifo_rdreq=0, pointers=0 and inflight shift register cleared; out_data is don't-care.
REQ-025 An sclr during in-flight reads SHALL discard those returns; captures SHALL resume only for rdreqs issued after sclr deasserts.
REQ-026 The first fifo_rdreq SHALL be possible in the first cycle with sclr=0.

Structure
REQ-027 Package scfifo_pkg SHALL hold the legal READ_LATENCY values and a count-width function used for out_count.
REQ-028 A single sub-module, scfifo_reader_skid, SHALL implement the circular skid buffer (push, pop, count). Rdreq and inflight logic SHALL stay in the top level.

Verification
REQ-029 Streaming: pair with scfifo, READ_LATENCY=1, preload 10..41, out_ready=1 -> out_data = 10..41 on consecutive cycles, first word 2 cycles after first rdreq.
REQ-030 Backpressure: READ_LATENCY=2, out_ready=0 for 20 cycles with FIFO non-empty -> exactly 3 rdreqs issued, out_count=3, out_data stable; after release, order intact.
REQ-031 Random: 10000 cycles of random writes and random out_ready across both latencies -> scoreboard sees zero mismatches, and no rdreq ever occurs while fifo_empty=1.
REQ-032 Empty boundary: a single write into an empty FIFO -> exactly one rdreq, one transfer, then fifo_rdreq=0 with out_valid=0.
REQ-033 Reset mid-flight: sclr asserted for 1 cycle one cycle after a rdreq, READ_LATENCY=2 -> no capture, out_valid=0, and the next output is the first word written after sclr.
REQ-034 Simultaneous: buffer full, pop and capture in the same cycle -> out_count unchanged and the next head is correct.
